// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing generator.
package vga_timing_pkg;

  // 640x480@60 with a 25 MHz pixel rate derived from a 50 MHz reference.
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // Line/frame length from its four segments.
  function automatic int seg_total(int s, int b, int a, int f);
    return s + b + a + f;
  endfunction

  localparam int DEF_H_TOTAL = seg_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
  localparam int DEF_V_TOTAL = seg_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);

  // Raw per-pixel flags carried down the display-alignment pipeline.
  typedef struct packed {
    logic hs;   // inside horizontal sync window
    logic vs;   // inside vertical sync window
    logic act;  // inside active picture
  } sync_flags_t;

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, rst_i, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per enable; cleared by reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q <= '0;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing: pixel-tick divider, h/v counters, fetch-ahead address,
// LATENCY-aligned syncs/video_on and blanked colour register.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter bit HS_POL   = POL_ACTIVE_LOW,
  parameter bit VS_POL   = POL_ACTIVE_LOW,
  parameter int COLOR_W  = 3,
  parameter int LATENCY  = 1,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic               clock_ref,
  input  logic               reset,
  input  logic [COLOR_W-1:0] iRGB,
  output logic               h_sync,
  output logic               v_sync,
  output logic [COL_W-1:0]   column,
  output logic [ROW_W-1:0]   row,
  output logic               fetch,
  output logic               video_on,
  output logic [COLOR_W-1:0] oRGB,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOTAL = seg_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = seg_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int H_ACT_S = H_SYNC + H_BACK;
  localparam int H_ACT_E = H_ACT_S + H_ACTIVE;
  localparam int V_ACT_S = V_SYNC + V_BACK;
  localparam int V_ACT_E = V_ACT_S + V_ACTIVE;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  logic             run_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HC_W-1:0]  h_q, h_d;
  logic [VC_W-1:0]  v_q, v_d;
  logic             tick, tick_d;

  // run_q holds the divider for the first cycle after reset, so the
  // first tick lands on the CLK_DIV-th cycle after release.
  always_comb begin
    tick   = run_q && (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    if (run_q) div_d = tick ? '0 : div_q + 1'b1;
    if (tick) begin
      if (h_q == HC_W'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VC_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    tick_d = (div_d == DIV_W'(CLK_DIV - 1));
  end

  // Divider and raster counters.
  always_ff @(posedge clock_ref) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      run_q <= 1'b1;
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Raw region decode of the position being issued this tick.
  logic        h_act, v_act, active;
  logic [COL_W-1:0] col_raw;
  logic [ROW_W-1:0] row_raw;
  sync_flags_t raw_flags, dly_flags;

  assign h_act   = (h_q >= HC_W'(H_ACT_S)) && (h_q < HC_W'(H_ACT_E));
  assign v_act   = (v_q >= VC_W'(V_ACT_S)) && (v_q < VC_W'(V_ACT_E));
  assign active  = h_act && v_act;
  assign col_raw = COL_W'(h_q - HC_W'(H_ACT_S));
  assign row_raw = ROW_W'(v_q - VC_W'(V_ACT_S));

  assign raw_flags.hs  = (h_q < HC_W'(H_SYNC));
  assign raw_flags.vs  = (v_q < VC_W'(V_SYNC));
  assign raw_flags.act = active;

  vga_delay_line #(
    .WIDTH ($bits(sync_flags_t)),
    .DEPTH (LATENCY)
  ) u_dly (
    .clk_i (clock_ref),
    .rst_i (reset),
    .en_i  (tick),
    .d_i   (raw_flags),
    .q_o   (dly_flags)
  );

  logic               h_sync_q, v_sync_q, fetch_q, video_on_q, fs_q, ls_q;
  logic [COL_W-1:0]   column_q;
  logic [ROW_W-1:0]   row_q;
  logic [COLOR_W-1:0] rgb_q;

  // Output registers: tick-updated video outputs, strobes pre-decoded from
  // next state so they are high exactly during the tick cycle.
  always_ff @(posedge clock_ref) begin
    if (reset) begin
      h_sync_q   <= !HS_POL;
      v_sync_q   <= !VS_POL;
      fetch_q    <= 1'b0;
      video_on_q <= 1'b0;
      column_q   <= '0;
      row_q      <= '0;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      fs_q <= tick_d && (h_d == '0) && (v_d == '0);
      ls_q <= tick_d && (h_d == '0);
      if (tick) begin
        fetch_q    <= active;
        column_q   <= active ? col_raw : '0;
        row_q      <= active ? row_raw : '0;
        h_sync_q   <= dly_flags.hs ? HS_POL : !HS_POL;
        v_sync_q   <= dly_flags.vs ? VS_POL : !VS_POL;
        video_on_q <= dly_flags.act;
        rgb_q      <= dly_flags.act ? iRGB : '0;
      end
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign fetch       = fetch_q;
  assign video_on    = video_on_q;
  assign column      = column_q;
  assign row         = row_q;
  assign oRGB        = rgb_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Randomized bench: reference model works from "ticks since reset" arithmetic,
// expected outputs go into a scoreboard queue, a monitor compares on negedge.
module tb_vga_timing_generator;

  localparam int D    = 3;
  localparam int HS   = 3, HB = 2, HA = 5, HF = 2;
  localparam int VS   = 2, VB = 1, VA = 3, VF = 2;
  localparam int L    = 2;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int CW   = 4, COLW = 3, ROWW = 2;
  localparam int HT   = HS + HB + HA + HF;
  localparam int VT   = VS + VB + VA + VF;
  localparam int F    = HT * VT;
  localparam int NCYC = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   rgb;
  logic            h_sync, v_sync, fetch, video_on, frame_start, line_start;
  logic [COLW-1:0] column;
  logic [ROWW-1:0] row;
  logic [CW-1:0]   oRGB;

  always #5 clk = ~clk;

  vga_timing_generator #(
    .CLK_DIV(D), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(HPOL), .VS_POL(VPOL), .COLOR_W(CW), .LATENCY(L),
    .COL_W(COLW), .ROW_W(ROWW)
  ) dut (
    .clock_ref(clk), .reset(rst), .iRGB(rgb),
    .h_sync(h_sync), .v_sync(v_sync), .column(column), .row(row),
    .fetch(fetch), .video_on(video_on), .oRGB(oRGB),
    .frame_start(frame_start), .line_start(line_start)
  );

  typedef struct {
    logic hs, vs, fetch, von, fs, ls;
    int   col, row, rgb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, popped = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at sample %0d: got %0h expected %0h", name, popped, act, exp);
    end
  endtask

  function automatic bit in_win(int x, int s, int len);
    return (x >= s) && (x < s + len);
  endfunction

  // n = non-reset edges since the last reset edge, t = ticks completed,
  // c_rgb = iRGB captured on the latest tick edge.
  function automatic exp_t model(int n, int t, int c_rgb);
    exp_t e;
    int   p, h, v, c;
    e = '{hs: !HPOL, vs: !VPOL, fetch: 1'b0, von: 1'b0, fs: 1'b0, ls: 1'b0,
          col: 0, row: 0, rgb: 0};
    if (n > 0 && n % D == 0) begin
      p = t % F;
      e.fs = (p == 0);
      e.ls = (p % HT == 0);
    end
    if (t > 0) begin
      c = t - 1;
      p = c % F; h = p % HT; v = p / HT;
      if (in_win(h, HS + HB, HA) && in_win(v, VS + VB, VA)) begin
        e.fetch = 1'b1;
        e.col   = h - (HS + HB);
        e.row   = v - (VS + VB);
      end
      if (c >= L) begin
        p = (c - L) % F; h = p % HT; v = p / HT;
        e.hs  = (h < HS) ? HPOL : !HPOL;
        e.vs  = (v < VS) ? VPOL : !VPOL;
        e.von = in_win(h, HS + HB, HA) && in_win(v, VS + VB, VA);
        e.rgb = e.von ? c_rgb : 0;
      end
    end
    return e;
  endfunction

  // Stimulus + reference model.
  initial begin
    int n, t, prev_t, last_rgb;
    n = 0; t = 0; prev_t = 0; last_rgb = 0;
    rst = 1'b1;
    rgb = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (rst) begin
        n = 0; t = 0; prev_t = 0;
      end else begin
        n++;
        t = (n - 1) / D;
        if (t > prev_t) last_rgb = int'(rgb);
        prev_t = t;
      end
      sb.push_back(model(n, t, last_rgb));
      #1;
      rst = (cyc < 3) || (cyc == 1500) || ($urandom_range(0, 799) == 0);
      rgb = CW'($urandom);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("samples_compared", popped, NCYC);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: compare every presented output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        chk("h_sync",      int'(h_sync),      int'(e.hs));
        chk("v_sync",      int'(v_sync),      int'(e.vs));
        chk("fetch",       int'(fetch),       int'(e.fetch));
        chk("column",      int'(column),      e.col);
        chk("row",         int'(row),         e.row);
        chk("video_on",    int'(video_on),    int'(e.von));
        chk("oRGB",        int'(oRGB),        e.rgb);
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("line_start",  int'(line_start),  int'(e.ls));
      end
    end
  end

endmodule
